// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte transfers on a clk edge where tx_valid and tx_ready are both 1. The producer holds tx_data/tx_valid until that edge.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// All outputs are registered; fsm_state exposes the FSM (0=IDLE,1=START,2=DATA,3=PARITY,4=STOP).
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx_uart,
  output logic       tx_busy,
  output logic [2:0] fsm_state
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CYC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          stop_cnt, stop_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          parity_bit, parity_n;
  logic          line_n;
  logic          bit_end;

  assign bit_end   = (baud_cnt == CW'(BIT_CYC - 1));
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    parity_n   = parity_bit;
    line_n     = 1'b1;

    if (state != IDLE) baud_cnt_n = bit_end ? '0 : baud_cnt + CW'(1);

    case (state)
      IDLE: begin
        if (bus.tx_valid && bus.tx_ready) begin
          state_n    = START;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
          shreg_n    = bus.tx_data;
          parity_n   = ^bus.tx_data;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) state_n = IDLE;
          else stop_cnt_n = 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        stop_cnt_n = 1'b0;
      end
    endcase

    // The line is registered from the next state so it changes on the same edge as the FSM.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shreg_n[0];
      PARITY:  line_n = parity_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      parity_bit   <= 1'b0;
      tx_uart      <= 1'b1;
      tx_busy      <= 1'b0;
      bus.tx_ready <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_cnt_n;
      bit_idx      <= bit_idx_n;
      stop_cnt     <= stop_cnt_n;
      shreg        <= shreg_n;
      parity_bit   <= parity_n;
      tx_uart      <= line_n;
      tx_busy      <= (state_n != IDLE);
      bus.tx_ready <= (state_n == IDLE);
    end
  end
endmodule
